// File: rtl/ct_f_spsram_param_clr_if.sv
// Access bus of the clearable single-port SRAM: address, active-low enables and mask,
// write data, clear request, read data and clear-engine busy flag.
interface ct_f_spsram_param_clr_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [WIDTH-1:0]      WEN;
    logic [WIDTH-1:0]      D;
    logic                  CLR;
    logic [WIDTH-1:0]      Q;
    logic                  BUSY;

    modport master (output A, CEN, GWEN, WEN, D, CLR, input Q, BUSY);
    modport slave  (input A, CEN, GWEN, WEN, D, CLR, output Q, BUSY);
endinterface

// File: rtl/ct_f_spsram_param_clr.sv
// Parametrised single-port SRAM with per-bit masked write and a hardware clear engine.
// Optional macro SPSRAM_DOUT_REG_EN adds an output register (read latency 2).
module ct_f_spsram_param_clr #(
    parameter int              WIDTH      = 16,
    parameter int              DEPTH      = 128,
    parameter int              ADDR_WIDTH = 7,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                      CLK,
    input  logic                      RST,
    ct_f_spsram_param_clr_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]      q_q, q_d;
`ifdef SPSRAM_DOUT_REG_EN
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  rd_vld_q, rd_vld_d;
`endif

    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  busy;
    logic                  in_range;
    logic                  access_ok;
    logic                  rd_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_bmask;
    logic [WIDTH-1:0]      rd_word;

    // State register and datapath flops
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            q_q      <= '0;
`ifdef SPSRAM_DOUT_REG_EN
            rdata_q  <= '0;
            rd_vld_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
`ifdef SPSRAM_DOUT_REG_EN
            rdata_q  <= rdata_d;
            rd_vld_q <= rd_vld_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d = '0;
`ifdef SPSRAM_DOUT_REG_EN
                    state_d = ST_FLUSH;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            ST_IDLE: begin
                if (bus.CLR) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Output / memory-port decode; CLR wins over any access in the same cycle
    always_comb begin
        busy      = (state_q != ST_IDLE);
        in_range  = ({1'b0, bus.A} < DEPTH_W);
        access_ok = (state_q == ST_IDLE) && !bus.CLR && !bus.CEN;
        rd_en     = access_ok && bus.GWEN;
        mem_we    = 1'b0;
        mem_addr  = bus.A;
        mem_wdata = bus.D;
        mem_bmask = ~bus.WEN;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = INIT_VALUE;
            mem_bmask = '1;
        end else if (access_ok && !bus.GWEN && in_range) begin
            mem_we    = 1'b1;
        end
    end

    // Read path; out-of-range reads return zero
    always_comb begin
        rd_word = in_range ? mem[bus.A] : '0;
`ifdef SPSRAM_DOUT_REG_EN
        rdata_d  = rd_en ? rd_word : rdata_q;
        rd_vld_d = rd_en;
        q_d      = rd_vld_q ? rdata_q : q_q;
`else
        q_d      = rd_en ? rd_word : q_q;
`endif
    end

    // Single behavioural array with per-bit masked write
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (mem_bmask[i]) mem[mem_addr][i] <= mem_wdata[i];
            end
        end
    end

    assign bus.Q    = q_q;
    assign bus.BUSY = busy;

endmodule
